// File: rtl/bin_mac_pkg.sv
// Shared constants, FSM state type and output scaling helper for the
// sequential binary-weight multiply-accumulate layer.
package bin_mac_pkg;

    localparam int DEF_INPUT_DIM  = 16;
    localparam int DEF_OUTPUT_DIM = 8;
    localparam int DEF_BIT_CNT    = 8;
    localparam int DEF_LANES      = 4;
    localparam int DEF_SHIFT      = 0;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_e;

    // Arithmetic shift then clamp into the signed bit_cnt-wide output range;
    // the caller keeps only the low bit_cnt bits of the result.
    function automatic logic signed [31:0] sat_shift(input logic signed [31:0] acc,
                                                     input int shift,
                                                     input int bit_cnt);
        logic signed [31:0] shifted;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        shifted = acc >>> shift;
        hi      = (32'sd1 <<< (bit_cnt - 1)) - 32'sd1;
        lo      = -(32'sd1 <<< (bit_cnt - 1));
        if (shifted > hi) begin
            return hi;
        end else if (shifted < lo) begin
            return lo;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/bin_weight_mac_seq_if.sv
// Input/output handshake bundle of the binary-weight MAC layer; the master
// side is the producer/consumer pair, the slave side is the layer itself.
interface bin_weight_mac_seq_if
    import bin_mac_pkg::*;
#(
    parameter int INPUT_DIM  = DEF_INPUT_DIM,
    parameter int OUTPUT_DIM = DEF_OUTPUT_DIM,
    parameter int BIT_CNT    = DEF_BIT_CNT
) ();

    logic                                  in_valid;
    logic                                  in_ready;
    logic [INPUT_DIM-1:0][BIT_CNT-1:0]     value_in;
    logic                                  relu_en;
    logic [OUTPUT_DIM-1:0][INPUT_DIM-1:0]  weight;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [OUTPUT_DIM-1:0][BIT_CNT-1:0]    value_out;

    modport master (
        output in_valid, value_in, relu_en, weight, out_ready,
        input  in_ready, out_valid, value_out
    );

    modport slave (
        input  in_valid, value_in, relu_en, weight, out_ready,
        output in_ready, out_valid, value_out
    );

endinterface

// File: rtl/bin_lane_adder.sv
// Signed partial sum of one chunk of inputs for one output neuron:
// each input is added when its weight bit is 1 and subtracted when 0.
module bin_lane_adder
    import bin_mac_pkg::*;
#(
    parameter int LANES   = DEF_LANES,
    parameter int BIT_CNT = DEF_BIT_CNT,
    parameter int ACC_W   = DEF_BIT_CNT + $clog2(DEF_INPUT_DIM) + 1
) (
    input  logic [LANES-1:0][BIT_CNT-1:0] x_i,
    input  logic [LANES-1:0]              w_i,
    output logic signed [ACC_W-1:0]       sum_o
);

    logic signed [ACC_W-1:0] ext;

    always_comb begin
        sum_o = '0;
        ext   = '0;
        for (int l = 0; l < LANES; l++) begin
            ext   = {{(ACC_W-BIT_CNT){x_i[l][BIT_CNT-1]}}, x_i[l]};
            sum_o = w_i[l] ? (sum_o + ext) : (sum_o - ext);
        end
    end

endmodule

// File: rtl/bin_weight_mac_seq.sv
// Sequential binary-weight fully-connected layer: LANES inputs per cycle,
// all outputs in parallel, then shift/saturate/ReLU into a held output register.
module bin_weight_mac_seq
    import bin_mac_pkg::*;
#(
    parameter int INPUT_DIM  = DEF_INPUT_DIM,
    parameter int OUTPUT_DIM = DEF_OUTPUT_DIM,
    parameter int BIT_CNT    = DEF_BIT_CNT,
    parameter int LANES      = DEF_LANES,
    parameter int SHIFT      = DEF_SHIFT
) (
    input logic                 clk,
    input logic                 rst_n,
    bin_weight_mac_seq_if.slave bus
);

    localparam int N     = INPUT_DIM / LANES;
    localparam int ACC_W = BIT_CNT + $clog2(INPUT_DIM) + 1;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_e                                state_q;
    logic [CNT_W-1:0]                      cnt_q;
    logic [INPUT_DIM-1:0][BIT_CNT-1:0]     x_q;
    logic                                  relu_q;
    logic signed [ACC_W-1:0]               acc_q    [OUTPUT_DIM];
    logic                                  valid_q;
    logic [OUTPUT_DIM-1:0][BIT_CNT-1:0]    out_q;

    logic [LANES-1:0][BIT_CNT-1:0]         x_chunk;
    logic [LANES-1:0]                      w_chunk  [OUTPUT_DIM];
    logic signed [ACC_W-1:0]               part     [OUTPUT_DIM];
    logic signed [ACC_W-1:0]               acc_next [OUTPUT_DIM];
    logic [OUTPUT_DIM-1:0][BIT_CNT-1:0]    out_d;
    logic [BIT_CNT-1:0]                    res_sat;
    int                                    base;

    assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign bus.out_valid = valid_q;
    assign bus.value_out = out_q;

    always_comb begin
        base    = int'(cnt_q) * LANES;
        x_chunk = x_q[base +: LANES];
        for (int o = 0; o < OUTPUT_DIM; o++) begin
            w_chunk[o] = bus.weight[o][base +: LANES];
        end
    end

    for (genvar o = 0; o < OUTPUT_DIM; o++) begin : g_lane
        bin_lane_adder #(
            .LANES   (LANES),
            .BIT_CNT (BIT_CNT),
            .ACC_W   (ACC_W)
        ) u_adder (
            .x_i   (x_chunk),
            .w_i   (w_chunk[o]),
            .sum_o (part[o])
        );
    end

    // Result of the final accumulate is scaled here so it can be registered
    // on the same edge that completes the last chunk.
    always_comb begin
        res_sat = '0;
        for (int o = 0; o < OUTPUT_DIM; o++) begin
            acc_next[o] = acc_q[o] + part[o];
            res_sat     = BIT_CNT'(sat_shift(32'(acc_next[o]), SHIFT, BIT_CNT));
            out_d[o]    = (relu_q && res_sat[BIT_CNT-1]) ? '0 : res_sat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            relu_q  <= 1'b0;
            valid_q <= 1'b0;
            out_q   <= '0;
            for (int o = 0; o < OUTPUT_DIM; o++) begin
                acc_q[o] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_q     <= bus.value_in;
                        relu_q  <= bus.relu_en;
                        cnt_q   <= '0;
                        state_q <= ACCUM;
                        for (int o = 0; o < OUTPUT_DIM; o++) begin
                            acc_q[o] <= '0;
                        end
                    end
                end
                ACCUM: begin
                    for (int o = 0; o < OUTPUT_DIM; o++) begin
                        acc_q[o] <= acc_next[o];
                    end
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        out_q   <= out_d;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    // Handshake and a fresh accept may share one edge.
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        if (bus.in_valid) begin
                            x_q     <= bus.value_in;
                            relu_q  <= bus.relu_en;
                            cnt_q   <= '0;
                            state_q <= ACCUM;
                            for (int o = 0; o < OUTPUT_DIM; o++) begin
                                acc_q[o] <= '0;
                            end
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_weight_mac_seq.sv
// Directed self-checking bench for bin_weight_mac_seq at default parameters.
module tb_bin_weight_mac_seq;

    typedef logic [15:0][7:0] vec_t;
    typedef logic [7:0][15:0] wgt_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   passes;
    int   fails;
    int   cycle;
    int   lat;
    int   lastRise;
    vec_t xv;
    wgt_t wv;

    bin_weight_mac_seq_if #(.INPUT_DIM(16), .OUTPUT_DIM(8), .BIT_CNT(8)) bus ();

    bin_weight_mac_seq #(
        .INPUT_DIM  (16),
        .OUTPUT_DIM (8),
        .BIT_CNT    (8),
        .LANES      (4),
        .SHIFT      (0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t fillX(input logic [7:0] v);
        vec_t r;
        for (int j = 0; j < 16; j++) r[j] = v;
        return r;
    endfunction

    function automatic wgt_t fillW(input logic [15:0] v);
        wgt_t r;
        for (int o = 0; o < 8; o++) r[o] = v;
        return r;
    endfunction

    function automatic vec_t genX(input int k);
        vec_t r;
        for (int j = 0; j < 16; j++) r[j] = 8'(k * 37 + j * 11 - 90);
        return r;
    endfunction

    function automatic wgt_t genW(input int k);
        wgt_t r;
        for (int o = 0; o < 8; o++) r[o] = 16'(k * 16'h3A5B + o * 16'h01F3 + 16'h0F0F);
        return r;
    endfunction

    // Reference: straight per-neuron signed sum, clamp, optional ReLU.
    function automatic logic [63:0] model(input vec_t x, input wgt_t w, input logic r);
        logic [63:0]        y;
        logic signed [31:0] s;
        logic signed [31:0] e;
        y = '0;
        for (int o = 0; o < 8; o++) begin
            s = 0;
            for (int j = 0; j < 16; j++) begin
                e = 32'($signed(x[j]));
                s = w[o][j] ? s + e : s - e;
            end
            if (s > 127) s = 127;
            if (s < -128) s = -128;
            if (r && s < 0) s = 0;
            y[o*8 +: 8] = s[7:0];
        end
        return y;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t x, input wgt_t w, input logic r);
        bus.value_in = x;
        bus.weight   = w;
        bus.relu_en  = r;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic waitValid(output int n);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic runVector(input string tag, input vec_t x, input wgt_t w,
                             input logic r, input logic [63:0] exp);
        int n;
        bus.out_ready = 1'b1;
        applyStimulus(x, w, r);
        waitValid(n);
        checkOutput({tag, "_lat"}, 64'(n), 64'd4);
        checkOutput({tag, "_val"}, bus.value_out, exp);
        tick();
        checkOutput({tag, "_vfall"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        checks = 0; passes = 0; fails = 0; cycle = 0; lastRise = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.relu_en = 1'b0;
        bus.value_in = '0; bus.weight = '0;
        tick(); tick();
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_value_out", bus.value_out, 64'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] basic sum");
        runVector("basic", fillX(8'd1), fillW(16'hFFFF), 1'b0, 64'h1010101010101010);

        $display("[TB] alternating signs");
        for (int j = 0; j < 16; j++) xv[j] = 8'(j);
        runVector("alt", xv, fillW(16'h5555), 1'b0, 64'hF8F8F8F8F8F8F8F8);
        runVector("alt_relu", xv, fillW(16'h5555), 1'b1, 64'h0);

        $display("[TB] saturation");
        runVector("sat_pos", fillX(8'd100), fillW(16'hFFFF), 1'b0, 64'h7F7F7F7F7F7F7F7F);
        runVector("sat_neg", fillX(8'd100), fillW(16'h0000), 1'b0, 64'h8080808080808080);
        runVector("sat_min", fillX(8'h80), fillW(16'h0000), 1'b0, 64'h7F7F7F7F7F7F7F7F);

        $display("[TB] backpressure");
        bus.out_ready = 1'b0;
        applyStimulus(fillX(8'd1), fillW(16'hFFFF), 1'b0);
        waitValid(lat);
        checkOutput("bp_lat", 64'(lat), 64'd4);
        bus.value_in = fillX(8'd2);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_in_ready", 64'(bus.in_ready), 64'd0);
            tick();
            checkOutput("bp_hold_val", bus.value_out, 64'h1010101010101010);
            checkOutput("bp_hold_valid", 64'(bus.out_valid), 64'd1);
        end
        bus.out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        checkOutput("bp_vfall", 64'(bus.out_valid), 64'd0);
        waitValid(lat);
        checkOutput("bp_next_lat", 64'(lat), 64'd4);
        checkOutput("bp_next_val", bus.value_out, 64'h2020202020202020);
        tick();

        $display("[TB] reset mid-operation");
        applyStimulus(fillX(8'd5), fillW(16'hFFFF), 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("mid_rst_value", bus.value_out, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        runVector("post_rst", fillX(8'd1), fillW(16'hFFFF), 1'b0, 64'h1010101010101010);

        $display("[TB] throughput");
        bus.out_ready = 1'b1;
        bus.relu_en   = 1'b0;
        bus.value_in  = genX(0);
        bus.weight    = genW(0);
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            checkOutput("tp_in_ready", 64'(bus.in_ready), 64'd1);
            tick();
            if (k < 9) bus.value_in = genX(k + 1);
            else bus.in_valid = 1'b0;
            waitValid(lat);
            checkOutput("tp_lat", 64'(lat), 64'd4);
            if (k > 0) checkOutput("tp_period", 64'(cycle - lastRise), 64'd5);
            lastRise = cycle;
            checkOutput("tp_val", bus.value_out, model(genX(k), genW(k), 1'b0));
            if (k < 9) bus.weight = genW(k + 1);
        end
        tick();
        checkOutput("tp_end_valid", 64'(bus.out_valid), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/bin_weight_mac_seq.md
Name: bin_weight_mac_seq

Overview:
Sequential, parametrised successor to the combinational fixed-point-in / binary-weight layer. It computes one fully-connected layer, y[o] = sum_j (w[o][j] ? +x[j] : -x[j]). Inputs are processed LANES at a time over INPUT_DIM/LANES cycles, all OUTPUT_DIM outputs in parallel. Output scaling, saturation and optional ReLU are applied, with valid/ready handshakes on both sides. It sits between the activation buffer and the next layer in the BNN inference datapath.

Parameters:
INPUT_DIM, 16, number of input activations per vector; must be a multiple of LANES.
OUTPUT_DIM, 8, number of output neurons.
BIT_CNT, 8, width of signed two's-complement input and output values.
LANES, 4, inputs consumed per accumulate cycle.
SHIFT, 0, arithmetic right shift applied to the accumulator before saturation.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  value_in and relu_en are valid.
in_ready  out  1  block can accept a vector this cycle.
value_in  in  [INPUT_DIM-1:0][BIT_CNT-1:0]  signed input vector.
relu_en  in  1  clamp negative results to 0; sampled at accept.
weight  in  [OUTPUT_DIM-1:0][INPUT_DIM-1:0]  binary weights; 1 = +1, 0 = -1. Must be held stable from accept until the output handshake.
out_valid  out  1  value_out is valid.
out_ready  in  1  downstream accepts value_out.
value_out  out  [OUTPUT_DIM-1:0][BIT_CNT-1:0]  signed saturated result.

Behaviour:
- Constants: N = INPUT_DIM/LANES; ACC_W = BIT_CNT + $clog2(INPUT_DIM) + 1.
- Accumulators are signed ACC_W bits and cannot overflow.
- FSM states are IDLE, ACCUM and DONE.
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, value_out=0, accumulators=0, chunk counter=0.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational from the state and out_ready.
- Accept occurs on an edge where in_valid && in_ready.
  - On accept: latch value_in and relu_en, clear the accumulators and the chunk counter, and go to ACCUM.
- ACCUM, each cycle for chunk c:
  - For every o, acc[o] += sum over l of (weight[o][c*LANES+l] ? +x : -x), where x = latched value_in[c*LANES+l], sign-extended to ACC_W.
  - c increments. After chunk N-1, go to DONE.
- DONE entry, same edge as the last accumulate: register value_out[o] = relu(sat(acc_final[o] >>> SHIFT)) and set out_valid=1.
  - sat clamps to [-2^(BIT_CNT-1), 2^(BIT_CNT-1)-1].
  - relu maps negative values to 0 when the latched relu_en=1.
- Latency: out_valid rises exactly N rising edges after the accepting edge.
- DONE with out_ready=0: value_out and out_valid are held unchanged. in_ready=0. in_valid is ignored.
- DONE with out_ready=1:
  - Output handshake completes.
  - If in_valid=1 on the same edge, the new vector is accepted and the state goes to ACCUM. out_valid falls.
  - Otherwise go to IDLE with out_valid=0.
- Back-to-back throughput is one vector per N+1 cycles.
- value_out keeps its last value after the handshake. It is only meaningful while out_valid=1.
- in_valid while in ACCUM is ignored, since in_ready=0. No internal queueing.
- rst_n low mid-ACCUM or mid-DONE: immediately return to the reset values. The partial result is discarded and never presented.
- N=1: ACCUM lasts one cycle, latency 1.

Decomposition:
- Package bin_mac_pkg holds the default parameter constants, a helper function sat_shift(acc, SHIFT, BIT_CNT), and the state enum typedef {IDLE, ACCUM, DONE}.
- Sub-module bin_lane_adder: combinational; takes LANES signed inputs and LANES weight bits, returns a signed ACC_W partial sum. It is instantiated OUTPUT_DIM times.
- The top level holds the FSM, chunk counter, input latch, accumulators and output register.

Test Plan:
All scenarios use the defaults (INPUT_DIM=16, LANES=4, OUTPUT_DIM=8, BIT_CNT=8, SHIFT=0).
1. Basic sum: all x=1, all weights 1, relu_en=0, out_ready=1 -> every value_out = 16; out_valid rises 4 edges after accept and is high 1 cycle.
2. Alternating signs: x[j]=j, weight[o][j]=1 for even j and 0 for odd j -> every value_out = 56-64 = -8. With relu_en=1 -> 0.
3. Saturation: all x=100 with all weights 1 -> 127 (sum 1600). All weights 0 -> -128. All x=-128 with weights 0 -> 127.
4. Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 and a new vector -> value_out stable, in_ready=0, no accept. Then set out_ready=1 -> handshake and the new vector are accepted on the same edge; the next result appears 4 edges later.
5. Reset mid-operation: assert rst_n=0 at the 2nd ACCUM cycle -> out_valid=0, in_ready=1, value_out=0 immediately. A following vector of all 1s yields 16, not a stale sum.
6. Throughput: continuous in_valid=1 and out_ready=1 for 10 vectors -> 10 results in order, one every 5 cycles, matching the software reference model.
